bullet_pool: RTL
================

Name: bullet_pool

Overview:
- Parametrised successor of the single-bullet draw/erase engine.
- Manages up to NUM_BULLETS player bullets in a slot table: spawns on fire, advances each live bullet once per frame tick, retires at the top edge or on hit.
- Emits a serialised pixel stream (erase old, draw new) to the shared VGA plotter.
- Sits between the ship/input logic and the framebuffer arbiter.

Parameters:
- NUM_BULLETS, 4, slot count (1..8).
- BW, 2, bullet width in pixels (1..4).
- BH, 3, bullet height in pixels (1..4).
- SPEED, 2, pixels moved up per frame tick (1..7).
- X_OFF, 5, spawn x offset from ship_x.
- Y_MIN, 0, top boundary row.
- COLOUR, 3'b101, draw colour. Erase colour is always 3'b000.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- fire  in  1  one-cycle fire request
- ship_x  in  9  ship left x
- ship_y  in  8  ship top y
- frame_tick  in  1  one-cycle frame update strobe
- hit_valid  in  1  collision report strobe
- hit_idx  in  3  slot index of the hit bullet
- plot  out  1  pixel write valid
- x  out  9  pixel x
- y  out  8  pixel y
- colour  out  3  pixel colour
- busy  out  1  frame pass in progress
- fire_drop  out  1  one-cycle pulse: fire discarded, no free slot
- overrun  out  1  one-cycle pulse: frame_tick arrived while busy
- active  out  NUM_BULLETS  per-slot live flag
- pos_x_flat  out  9*NUM_BULLETS  per-slot x, slot i at [9i+8:9i]
- pos_y_flat  out  8*NUM_BULLETS  per-slot y, slot i at [8i+7:8i]

Behaviour:
- Reset: clk/reset as specified; asynchronous, active-high. All outputs are 0; all slots inactive; dying flags clear; FSM in IDLE. Reset mid-pass aborts the pass immediately. Pixels already plotted are not cleaned up.
- Per-slot state: active, dying, x[8:0], y[7:0].
- FSM states: IDLE, SCAN, ERASE, MOVE, DRAW.
- IDLE:
  - A pending fire is serviced first. Fire is latched in a 1-deep pending flag from any state.
  - Service allocates the lowest-index inactive slot: x = ship_x + X_OFF (9-bit wrap), y = ship_y - BH, active = 1.
  - If no slot is free, pulse fire_drop and clear the pending flag.
  - A new bullet is first drawn on the next frame pass.
  - On frame_tick, go to SCAN with slot index 0 and raise busy.
  - If fire and frame_tick coincide, the spawn takes effect before the pass begins.
- SCAN:
  - Inactive slot: advance the index, 1 cycle.
  - Active slot: go to ERASE.
  - After the last slot, return to IDLE and drop busy.
- ERASE: BW*BH cycles, plot=1, colour=000. Row-major order: col counter 0..BW-1 inner, row 0..BH-1 outer. x = slot_x + col, y = slot_y + row.
- MOVE: 1 cycle, plot=0.
  - If dying, or slot_y < Y_MIN + SPEED: active = 0, clear dying, back to SCAN (next index).
  - Otherwise slot_y -= SPEED, go to DRAW.
- DRAW: BW*BH cycles, same order, colour=COLOUR, then SCAN (next index).
- Pixel outputs: plot, x, y and colour are registered and valid together. plot is 0 in IDLE, SCAN and MOVE.
- Pass timing: a pass with k live non-retiring slots takes exactly NUM_BULLETS + k*(2*BW*BH + 1) + 1 cycles from the frame_tick edge to busy falling.
- hit_valid:
  - If active[hit_idx] is set, set dying[hit_idx]. The bullet is erased and retired in the next pass it reaches, without being redrawn.
  - A hit on an inactive slot or an out-of-range index is ignored.
  - If a hit lands during the same slot's DRAW, the drawing completes; retirement happens next pass.
- frame_tick while busy: ignored; pulse overrun.
- Arithmetic: all in 9/8-bit unsigned. Bullets wider than the screen wrap; clipping is the plotter's job.

Decomposition:
- Shared package (alongside the other sprite engines): colour constants (BLACK = 3'b000, MAGENTA = 3'b101), screen bounds (320x240), FSM state encoding localparams.
- One natural sub-module: sprite_pixel_scan (start, base_x, base_y, BW/BH params -> x, y, plot, done). It is reusable for the alien and ship engines.

Test Plan:
1. Reset, then fire with ship_x=100, ship_y=200 -> active=0001, slot0 x=105, y=197. No plot until frame_tick. First tick: 6 erase pixels at (105..106,197..199), then 6 draw pixels at (105..106,195..197), colour 101.
2. Four fires, then a fifth -> active=1111; fifth pulses fire_drop. Next tick: busy for 4+4*13+1=57 cycles.
3. Slot at y=1, SPEED=2, Y_MIN=0 -> erase 6 pixels, then active bit clears, no draw.
4. hit_valid, hit_idx=2 on a live slot2 -> next pass erases slot2 only, active[2]=0. Slots 0, 1 and 3 are redrawn normally.
5. frame_tick held during a pass -> overrun pulses, pass length unchanged. Simultaneous fire+tick in IDLE -> new bullet included in the same pass.
6. Assert reset mid-ERASE -> plot, busy and active are 0 asynchronously. A later tick produces no pixels.

Source files
------------

// File: rtl/bullet_pool_pkg.sv
// Shared definitions for the sprite engines: colours, screen bounds,
// FSM state encodings and the bullet slot record.
package bullet_pool_pkg;

  localparam logic [2:0] BLACK   = 3'b000;
  localparam logic [2:0] MAGENTA = 3'b101;

  localparam int SCREEN_W = 320;
  localparam int SCREEN_H = 240;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SCAN  = 3'd1;
  localparam logic [2:0] ST_ERASE = 3'd2;
  localparam logic [2:0] ST_MOVE  = 3'd3;
  localparam logic [2:0] ST_DRAW  = 3'd4;

  typedef struct packed {
    logic       active;
    logic       dying;
    logic [8:0] x;
    logic [7:0] y;
  } slot_t;

endpackage

// File: rtl/bullet_pool_pixel_scan.sv
// Row-major BW x BH rectangle walker with registered pixel outputs.
// done_o is high on the final pixel cycle; start_i latches the base corner.
module sprite_pixel_scan #(
  parameter int BW = 2,
  parameter int BH = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_i,
  input  logic [8:0] base_x_i,
  input  logic [7:0] base_y_i,
  output logic [8:0] x_o,
  output logic [7:0] y_o,
  output logic       plot_o,
  output logic       done_o
);

  localparam logic [1:0] LAST_COL = 2'(BW - 1);
  localparam logic [1:0] LAST_ROW = 2'(BH - 1);

  logic [8:0] bx_q, bx_d, x_q, x_d;
  logic [7:0] by_q, by_d, y_q, y_d;
  logic [1:0] col_q, col_d, row_q, row_d;
  logic       plot_q, plot_d;
  logic       last_s;

  assign last_s = (col_q == LAST_COL) && (row_q == LAST_ROW);

  always_comb begin
    bx_d   = bx_q;
    by_d   = by_q;
    col_d  = col_q;
    row_d  = row_q;
    plot_d = plot_q;
    x_d    = x_q;
    y_d    = y_q;
    if (start_i) begin
      bx_d   = base_x_i;
      by_d   = base_y_i;
      col_d  = 2'd0;
      row_d  = 2'd0;
      plot_d = 1'b1;
      x_d    = base_x_i;
      y_d    = base_y_i;
    end else if (plot_q && last_s) begin
      plot_d = 1'b0;
    end else if (plot_q) begin
      if (col_q == LAST_COL) begin
        col_d = 2'd0;
        row_d = row_q + 2'd1;
      end else begin
        col_d = col_q + 2'd1;
      end
      // Coordinates wrap in 9/8 bits; clipping happens downstream.
      x_d = bx_q + {7'd0, col_d};
      y_d = by_q + {6'd0, row_d};
    end else begin
      plot_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bx_q   <= 9'd0;
      by_q   <= 8'd0;
      col_q  <= 2'd0;
      row_q  <= 2'd0;
      plot_q <= 1'b0;
      x_q    <= 9'd0;
      y_q    <= 8'd0;
    end else begin
      bx_q   <= bx_d;
      by_q   <= by_d;
      col_q  <= col_d;
      row_q  <= row_d;
      plot_q <= plot_d;
      x_q    <= x_d;
      y_q    <= y_d;
    end
  end

  assign x_o    = x_q;
  assign y_o    = y_q;
  assign plot_o = plot_q;
  assign done_o = plot_q & last_s;

endmodule

// File: rtl/bullet_pool.sv
// Multi-slot player bullet engine: spawns on fire, moves live bullets once per
// frame tick and serialises erase/draw pixels to the shared plotter.
module bullet_pool
  import bullet_pool_pkg::*;
#(
  parameter int         NUM_BULLETS = 4,
  parameter int         BW          = 2,
  parameter int         BH          = 3,
  parameter int         SPEED       = 2,
  parameter int         X_OFF       = 5,
  parameter int         Y_MIN       = 0,
  parameter logic [2:0] COLOUR      = MAGENTA
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     fire,
  input  logic [8:0]               ship_x,
  input  logic [7:0]               ship_y,
  input  logic                     frame_tick,
  input  logic                     hit_valid,
  input  logic [2:0]               hit_idx,
  output logic                     plot,
  output logic [8:0]               x,
  output logic [7:0]               y,
  output logic [2:0]               colour,
  output logic                     busy,
  output logic                     fire_drop,
  output logic                     overrun,
  output logic [NUM_BULLETS-1:0]   active,
  output logic [9*NUM_BULLETS-1:0] pos_x_flat,
  output logic [8*NUM_BULLETS-1:0] pos_y_flat
);

  localparam int         IW    = $clog2(NUM_BULLETS + 1);
  localparam logic [8:0] Y_LIM = 9'(Y_MIN + SPEED);

  slot_t          slot_q [NUM_BULLETS];
  slot_t          slot_d [NUM_BULLETS];
  logic [2:0]     state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           busy_q, busy_d;
  logic           pending_q, pending_d;
  logic           fire_drop_q, fire_drop_d;
  logic           overrun_q, overrun_d;
  logic [2:0]     colour_q, colour_d;

  slot_t          cur_s;
  logic           free_s;
  logic [IW-1:0]  free_idx_s;
  logic           scan_start_s, scan_done_s;
  logic [8:0]     scan_x_s;
  logic [7:0]     scan_y_s;

  sprite_pixel_scan #(.BW(BW), .BH(BH)) u_scan (
    .clk      (clk),
    .reset    (reset),
    .start_i  (scan_start_s),
    .base_x_i (scan_x_s),
    .base_y_i (scan_y_s),
    .x_o      (x),
    .y_o      (y),
    .plot_o   (plot),
    .done_o   (scan_done_s)
  );

  // Current slot selection and lowest-index free slot search.
  always_comb begin
    cur_s      = '0;
    free_s     = 1'b0;
    free_idx_s = '0;
    for (int i = 0; i < NUM_BULLETS; i++) begin
      if (idx_q == IW'(i)) cur_s = slot_q[i];
      else                 cur_s = cur_s;
    end
    for (int i = NUM_BULLETS - 1; i >= 0; i--) begin
      if (!slot_q[i].active) begin
        free_s     = 1'b1;
        free_idx_s = IW'(i);
      end else begin
        free_s     = free_s;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    busy_d       = busy_q;
    pending_d    = pending_q | fire;
    fire_drop_d  = 1'b0;
    overrun_d    = frame_tick & busy_q;
    colour_d     = colour_q;
    scan_start_s = 1'b0;
    scan_x_s     = cur_s.x;
    scan_y_s     = cur_s.y;
    for (int i = 0; i < NUM_BULLETS; i++) begin
      slot_d[i] = slot_q[i];
      if (hit_valid && (hit_idx == 3'(i)) && slot_q[i].active) slot_d[i].dying = 1'b1;
      else                                                     slot_d[i].dying = slot_q[i].dying;
    end

    case (state_q)
      ST_IDLE: begin
        pending_d = 1'b0;
        // Spawn first so a coincident frame_tick sees the new bullet.
        if ((pending_q || fire) && free_s) begin
          for (int i = 0; i < NUM_BULLETS; i++) begin
            if (free_idx_s == IW'(i)) begin
              slot_d[i].active = 1'b1;
              slot_d[i].dying  = 1'b0;
              slot_d[i].x      = ship_x + 9'(X_OFF);
              slot_d[i].y      = ship_y - 8'(BH);
            end else begin
              slot_d[i].active = slot_d[i].active;
            end
          end
        end else begin
          fire_drop_d = pending_q | fire;
        end
        if (frame_tick) begin
          state_d = ST_SCAN;
          idx_d   = '0;
          busy_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (idx_q == IW'(NUM_BULLETS)) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else if (cur_s.active) begin
          scan_start_s = 1'b1;
          colour_d     = BLACK;
          state_d      = ST_ERASE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_ERASE: begin
        state_d = scan_done_s ? ST_MOVE : ST_ERASE;
      end
      ST_MOVE: begin
        if (cur_s.dying || ({1'b0, cur_s.y} < Y_LIM)) begin
          for (int i = 0; i < NUM_BULLETS; i++) begin
            if (idx_q == IW'(i)) begin
              slot_d[i].active = 1'b0;
              slot_d[i].dying  = 1'b0;
            end else begin
              slot_d[i].active = slot_d[i].active;
            end
          end
          idx_d   = idx_q + 1'b1;
          state_d = ST_SCAN;
        end else begin
          scan_y_s = cur_s.y - 8'(SPEED);
          for (int i = 0; i < NUM_BULLETS; i++) begin
            if (idx_q == IW'(i)) slot_d[i].y = scan_y_s;
            else                 slot_d[i].y = slot_q[i].y;
          end
          scan_start_s = 1'b1;
          colour_d     = COLOUR;
          state_d      = ST_DRAW;
        end
      end
      ST_DRAW: begin
        if (scan_done_s) begin
          idx_d   = idx_q + 1'b1;
          state_d = ST_SCAN;
        end else begin
          state_d = ST_DRAW;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, slot table and strobe registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      busy_q      <= 1'b0;
      pending_q   <= 1'b0;
      fire_drop_q <= 1'b0;
      overrun_q   <= 1'b0;
      colour_q    <= BLACK;
      for (int i = 0; i < NUM_BULLETS; i++) slot_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      busy_q      <= busy_d;
      pending_q   <= pending_d;
      fire_drop_q <= fire_drop_d;
      overrun_q   <= overrun_d;
      colour_q    <= colour_d;
      for (int i = 0; i < NUM_BULLETS; i++) slot_q[i] <= slot_d[i];
    end
  end

  always_comb begin
    active     = '0;
    pos_x_flat = '0;
    pos_y_flat = '0;
    for (int i = 0; i < NUM_BULLETS; i++) begin
      active[i]           = slot_q[i].active;
      pos_x_flat[9*i +: 9] = slot_q[i].x;
      pos_y_flat[8*i +: 8] = slot_q[i].y;
    end
  end

  assign colour    = colour_q;
  assign busy      = busy_q;
  assign fire_drop = fire_drop_q;
  assign overrun   = overrun_q;

endmodule
